sddr_wl_calibrator: RTL and testbench
=====================================

# sddr_wl_calibrator

Multi-lane DDR3 write-leveling calibrator for the simple DDR controller PHY. Runs in the DDR clock domain between the controller and the per-lane DQS delay elements. For each byte lane it steps the DQS output delay one tap at a time and finds the 0→1 transition of CK as sampled by DQS and reported on the lane's DQ feedback bit. It reports the locked tap per lane, or a per-lane failure when the tap range is exhausted.

## Interface
Parameters:
- LANES, 2, number of byte lanes (DATA_BITS/8)
- TAP_BITS, 5, width of the delay tap counter; maximum tap = 2^TAP_BITS-1
- SETTLE_CYCLES, 16, cycles waited after each DQS pulse before sampling feedback; ≥1
- SAMPLES, 4, DQS pulses per tap when filtering is compiled in; ≥1

Ports:
- in_ddr_clock_i  in  1  DDR clock; all logic on its rising edge
- in_phy_reset_n_i  in  1  reset, asynchronous assert, active-low; one clock, asynchronous active-low reset
- ctl_start_i  in  1  start calibration; single-cycle pulse, honoured only in IDLE
- ctl_abort_i  in  1  abandon calibration; return to IDLE
- wl_dq_i  in  LANES  per-lane DQ feedback bit from the DRAM (already synchronised)
- ctl_out_dqs_o  out  1  one-cycle request to drive a DQS pulse on all lanes
- delay_ce_o  out  LANES  one-cycle increment strobe to the lane's delay element (INC tied high externally)
- tap_o  out  LANES*TAP_BITS  current tap per lane; lane n at bits [n*TAP_BITS +: TAP_BITS]
- ctl_busy_o  out  1  calibration in progress
- ctl_done_o  out  1  sticky; all lanes resolved
- lane_fail_o  out  LANES  sticky per-lane failure
- ctl_fail_o  out  1  OR of lane_fail_o, qualified by ctl_done_o

## Operation
- States: IDLE, PULSE, SETTLE, SAMPLE, STEP, FINISH.
- IDLE: on ctl_start_i, clear taps, locks, seen_zero, lane_fail_o and ctl_done_o; go to PULSE.
- PULSE: ctl_out_dqs_o=1 for one cycle; go to SETTLE.
- SETTLE: count SETTLE_CYCLES cycles; go to SAMPLE.
- SAMPLE: register the sample for every unresolved lane.
  - Sample 0: set seen_zero[n].
  - Sample 1 with seen_zero[n]=1: lock lane n at the current tap.
  - Sample 1 with seen_zero[n]=0: no lock; keep stepping.
  - If every lane is locked or failed, go to FINISH; otherwise go to STEP.
- STEP: for each unresolved lane, pulse delay_ce_o[n] and increment its tap, then go to PULSE.
  - A lane at maximum tap is not incremented; it sets lane_fail_o[n].
  - Resolved lanes never pulse again.
- FINISH: set ctl_done_o; go to IDLE.
- ctl_abort_i in any non-IDLE state: next state IDLE. Taps hold their value; ctl_done_o stays 0; lane_fail_o holds.
- Taps never wrap: the counter saturates at the maximum, and that lane fails.

## Timing
- Reset values: state IDLE; all outputs 0; tap_o all 0. The external delay elements must be reset by the same reset.
- One tap iteration takes 1 (PULSE) + SETTLE_CYCLES + 1 (SAMPLE) + 1 (STEP) cycles. When filtering is compiled in, each tap takes SAMPLES such iterations.
- delay_ce_o and the tap_o increment occur in the same cycle, so tap_o equals the delay count from the next cycle on.
- ctl_busy_o = 1 in every state except IDLE. ctl_done_o rises one cycle after FINISH is entered and is held until the next accepted start.
- ctl_start_i while busy: ignored.
- ctl_start_i and ctl_abort_i in the same cycle in IDLE: abort wins and the start is ignored.
- wl_dq_i is sampled only in SAMPLE and ignored elsewhere.

## Configuration
- SDDR_WL_FILTER_EN defined:
  - Each tap gets SAMPLES PULSE/SETTLE/SAMPLE rounds, with a per-lane count of ones (width $clog2(SAMPLES+1)).
  - The tap's sample is 1 if count > SAMPLES/2 (integer division).
  - STEP and the lock decision happen only after the last round.
- Undefined: one round per tap, raw wl_dq_i used as the sample, and the count logic is not built.

## Test plan
- LANES=2, model returns 0 for tap<7 and 1 for tap≥7 on both lanes → ctl_done_o=1, tap_o lane0=7 and lane1=7, ctl_fail_o=0, exactly 7 delay_ce_o pulses per lane.
- Lane0 transitions at tap 3 and lane1 at tap 20 → lane0 stops at 3 with no further delay_ce_o[0]; lane1 locks at 20; done asserted after lane1 resolves.
- Lane1 feedback stuck at 0 → lane_fail_o=2'b10, lane1 tap=31, ctl_fail_o=1, lane0 still locks normally.
- Feedback 1 at tap 0 through 4, 0 at 5 through 9, 1 from 10 on → lock at 10, not 0.
- ctl_abort_i during SETTLE at tap 4 → IDLE next cycle, busy=0, done=0, tap held at 4. A following start restarts from tap 0. Reset asserted mid-STEP → all outputs 0 immediately.
- With SDDR_WL_FILTER_EN, SAMPLES=4, feedback pattern 1,0,0,1 at tap 6 → no lock (2 ≤ 2). Pattern 1,1,0,1 at tap 7 → lock at 7.

Source files
------------

// File: rtl/sddr_wl_calibrator.sv
// DDR3 write-leveling calibrator: per lane, steps DQS delay until CK sampled by DQS goes 0->1.
// Latency: (1 + SETTLE_CYCLES + 1 + 1) cycles per round; one round per tap, or SAMPLES rounds when filtered.
// Backpressure: none; ctl_start_i is honoured only in IDLE, ctl_abort_i returns to IDLE from any busy state.
//
// Ports:
//   in_ddr_clock_i / in_phy_reset_n_i : DDR clock (rising edge), async active-low reset
//   ctl_start_i / ctl_abort_i         : start pulse (IDLE only) / abandon calibration
//   wl_dq_i                           : per-lane DQ feedback, sampled only in SAMPLE
//   ctl_out_dqs_o                     : one-cycle DQS pulse request for all lanes
//   delay_ce_o                        : per-lane one-cycle delay increment strobe
//   tap_o                             : per-lane tap, lane n at [n*TAP_BITS +: TAP_BITS]
//   ctl_busy_o / ctl_done_o           : calibration running / sticky all-lanes-resolved
//   lane_fail_o / ctl_fail_o          : sticky per-lane failure / any failure once done
//
// Build option: define SDDR_WL_FILTER_EN to majority-filter SAMPLES DQS pulses per tap.

module sddr_wl_calibrator #(
    parameter int unsigned LANES         = 2,
    parameter int unsigned TAP_BITS      = 5,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned SAMPLES       = 4
) (
    input  logic                      in_ddr_clock_i,
    input  logic                      in_phy_reset_n_i,
    input  logic                      ctl_start_i,
    input  logic                      ctl_abort_i,
    input  logic [LANES-1:0]          wl_dq_i,
    output logic                      ctl_out_dqs_o,
    output logic [LANES-1:0]          delay_ce_o,
    output logic [LANES*TAP_BITS-1:0] tap_o,
    output logic                      ctl_busy_o,
    output logic                      ctl_done_o,
    output logic [LANES-1:0]          lane_fail_o,
    output logic                      ctl_fail_o
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PULSE  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_SAMPLE = 3'd3;
    localparam logic [2:0] ST_STEP   = 3'd4;
    localparam logic [2:0] ST_FINISH = 3'd5;

    localparam int unsigned         SET_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0]    SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [TAP_BITS-1:0] TAP_MAX  = '1;

    logic [2:0]          state_q, state_d;
    logic [SET_W-1:0]    set_cnt_q, set_cnt_d;
    logic [TAP_BITS-1:0] tap_q [LANES];
    logic [TAP_BITS-1:0] tap_d [LANES];
    logic [LANES-1:0]    lock_q, lock_d;
    logic [LANES-1:0]    seen_zero_q, seen_zero_d;
    logic [LANES-1:0]    fail_q, fail_d;
    logic                done_q, done_d;
    logic [LANES-1:0]    step_ce;

    // A lane is resolved once it has either locked or run out of taps.
    logic [LANES-1:0]    resolved;
    assign resolved = lock_q | fail_q;

    // Per-lane sample value for the tap, and whether this round closes the tap.
    logic [LANES-1:0]    sample_bit;
    logic                last_round;

`ifdef SDDR_WL_FILTER_EN
    localparam int unsigned RND_W  = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
    localparam int unsigned ONES_W = $clog2(SAMPLES + 1);

    logic [RND_W-1:0]  rnd_q, rnd_d;
    logic [ONES_W-1:0] ones_q [LANES];
    logic [ONES_W-1:0] ones_d [LANES];
    logic [ONES_W-1:0] ones_sum [LANES];

    // Count includes the pulse being sampled this cycle so the last round decides immediately.
    always_comb begin
        for (int n = 0; n < LANES; n++) begin
            ones_sum[n]   = ones_q[n] + ONES_W'(wl_dq_i[n]);
            sample_bit[n] = (ones_sum[n] > ONES_W'(SAMPLES / 2));
        end
    end

    assign last_round = (rnd_q == RND_W'(SAMPLES - 1));

    always_comb begin
        rnd_d  = rnd_q;
        ones_d = ones_q;
        if (state_q == ST_IDLE) begin
            rnd_d = '0;
            for (int n = 0; n < LANES; n++) ones_d[n] = '0;
        end else if (!ctl_abort_i) begin
            if (state_q == ST_SAMPLE) begin
                for (int n = 0; n < LANES; n++) ones_d[n] = last_round ? '0 : ones_sum[n];
            end
            if (state_q == ST_STEP) begin
                rnd_d = last_round ? '0 : rnd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge in_ddr_clock_i or negedge in_phy_reset_n_i) begin
        if (!in_phy_reset_n_i) begin
            rnd_q <= '0;
            for (int n = 0; n < LANES; n++) ones_q[n] <= '0;
        end else begin
            rnd_q  <= rnd_d;
            ones_q <= ones_d;
        end
    end
`else
    // SAMPLES only matters when filtering is built.
    logic unused_samples;
    assign unused_samples = (SAMPLES > 0);

    assign sample_bit = wl_dq_i;
    assign last_round = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        set_cnt_d   = set_cnt_q;
        tap_d       = tap_q;
        lock_d      = lock_q;
        seen_zero_d = seen_zero_q;
        fail_d      = fail_q;
        done_d      = done_q;
        step_ce     = '0;

        case (state_q)
            ST_IDLE: begin
                // Abort in the same cycle suppresses the start.
                if (ctl_start_i && !ctl_abort_i) begin
                    for (int n = 0; n < LANES; n++) tap_d[n] = '0;
                    lock_d      = '0;
                    seen_zero_d = '0;
                    fail_d      = '0;
                    done_d      = 1'b0;
                    state_d     = ST_PULSE;
                end
            end
            ST_PULSE: begin
                set_cnt_d = '0;
                state_d   = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (set_cnt_q == SET_LAST) begin
                    state_d = ST_SAMPLE;
                end else begin
                    set_cnt_d = set_cnt_q + 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (last_round) begin
                    // A 1 only locks after a 0 has been seen, so an early 1-region
                    // (DQS already past the previous CK edge) is stepped through.
                    for (int n = 0; n < LANES; n++) begin
                        if (!resolved[n]) begin
                            if (!sample_bit[n]) begin
                                seen_zero_d[n] = 1'b1;
                            end else if (seen_zero_q[n]) begin
                                lock_d[n] = 1'b1;
                            end
                        end
                    end
                    state_d = (&(lock_d | fail_q)) ? ST_FINISH : ST_STEP;
                end else begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (last_round) begin
                    for (int n = 0; n < LANES; n++) begin
                        if (!resolved[n]) begin
                            // Saturate rather than wrap: the lane is out of range.
                            if (tap_q[n] == TAP_MAX) begin
                                fail_d[n] = 1'b1;
                            end else begin
                                step_ce[n] = 1'b1;
                                tap_d[n]   = tap_q[n] + 1'b1;
                            end
                        end
                    end
                end
                state_d = ST_PULSE;
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort freezes all results so taps keep matching the delay elements.
        if (ctl_abort_i && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            tap_d       = tap_q;
            lock_d      = lock_q;
            seen_zero_d = seen_zero_q;
            fail_d      = fail_q;
            done_d      = done_q;
            step_ce     = '0;
        end
    end

    always_ff @(posedge in_ddr_clock_i or negedge in_phy_reset_n_i) begin
        if (!in_phy_reset_n_i) begin
            state_q     <= ST_IDLE;
            set_cnt_q   <= '0;
            for (int n = 0; n < LANES; n++) tap_q[n] <= '0;
            lock_q      <= '0;
            seen_zero_q <= '0;
            fail_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            set_cnt_q   <= set_cnt_d;
            tap_q       <= tap_d;
            lock_q      <= lock_d;
            seen_zero_q <= seen_zero_d;
            fail_q      <= fail_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        tap_o = '0;
        for (int n = 0; n < LANES; n++) tap_o[n*TAP_BITS +: TAP_BITS] = tap_q[n];
    end

    assign ctl_out_dqs_o = (state_q == ST_PULSE);
    assign delay_ce_o    = step_ce;
    assign ctl_busy_o    = (state_q != ST_IDLE);
    assign ctl_done_o    = done_q;
    assign lane_fail_o   = fail_q;
    assign ctl_fail_o    = done_q & (|fail_q);

endmodule

// File: tb/tb_sddr_wl_calibrator.sv
module tb_sddr_wl_calibrator;

    localparam int LANES    = 2;
    localparam int TAP_BITS = 5;
    localparam int SETTLE   = 2;
    localparam int SAMPLES  = 4;
    localparam int L        = SETTLE + 3;          // cycles per round
    localparam int MAXT     = (1 << TAP_BITS) - 1;
`ifdef SDDR_WL_FILTER_EN
    localparam int R = SAMPLES;
`else
    localparam int R = 1;
`endif

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      start;
    logic                      abort;
    logic [LANES-1:0]          wl_dq;
    logic                      dqs;
    logic [LANES-1:0]          ce;
    logic [LANES*TAP_BITS-1:0] tap;
    logic                      busy;
    logic                      done;
    logic [LANES-1:0]          lfail;
    logic                      cfail;

    always #5 clk = ~clk;

    sddr_wl_calibrator #(
        .LANES(LANES), .TAP_BITS(TAP_BITS), .SETTLE_CYCLES(SETTLE), .SAMPLES(SAMPLES)
    ) dut (
        .in_ddr_clock_i  (clk),
        .in_phy_reset_n_i(rst_n),
        .ctl_start_i     (start),
        .ctl_abort_i     (abort),
        .wl_dq_i         (wl_dq),
        .ctl_out_dqs_o   (dqs),
        .delay_ce_o      (ce),
        .tap_o           (tap),
        .ctl_busy_o      (busy),
        .ctl_done_o      (done),
        .lane_fail_o     (lfail),
        .ctl_fail_o      (cfail)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Owned by the stimulus process.
    int test_id = 0;
    bit run     = 1'b0;
    int exp_nl;
    int exp_ce   [LANES];
    int exp_tap  [LANES];
    bit exp_fail [LANES];

    // Owned by the compare process: cycle index within a run and the delay-element model.
    int k = 0;
    int dly [LANES];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    endtask

    function automatic int lane_tap(input int n);
        return int'(tap[n*TAP_BITS +: TAP_BITS]);
    endfunction

    // DRAM feedback: CK as seen at DQS for a given delay and round within the tap.
    function automatic bit dq_pat(input int tid, input int lane, input int tp, input int rnd);
        case (tid)
            1: return tp >= 7;
            2: return (lane == 0) ? (tp >= 3) : (tp >= 20);
            3: return (lane == 0) ? (tp >= 5) : 1'b0;
            4: return (tp <= 4) || (tp >= 10);
            5: begin
                if (tp < 6)  return 1'b0;
                if (tp == 6) return (rnd == 0) || (rnd == 3);
                if (tp == 7) return rnd != 2;
                return 1'b1;
            end
            default: return 1'b0;
        endcase
    endfunction

    int rnd_idx;
    assign rnd_idx  = (k > 0) ? (((k - 1) / L) % R) : 0;
    assign wl_dq[0] = dq_pat(test_id, 0, dly[0], rnd_idx);
    assign wl_dq[1] = dq_pat(test_id, 1, dly[1], rnd_idx);

    // Outcome model: scan taps, majority-vote each, lock at the first 1 after a 0.
    task automatic build_model(input int tid);
        int ntaps;
        ntaps = 0;
        for (int n = 0; n < LANES; n++) begin
            bit seen;
            bit locked;
            int lt;
            seen = 0; locked = 0; lt = 0;
            for (int t = 0; t <= MAXT && !locked; t++) begin
                int ones;
                ones = 0;
                for (int r = 0; r < R; r++) ones += int'(dq_pat(tid, n, t, r));
                if (ones <= R / 2) seen = 1;
                else if (seen) begin locked = 1; lt = t; end
            end
            if (locked) begin
                exp_tap[n] = lt; exp_ce[n] = lt; exp_fail[n] = 0;
                if (lt + 1 > ntaps) ntaps = lt + 1;
            end else begin
                // Fails in the STEP at max tap, then one more tap pass before finishing.
                exp_tap[n] = MAXT; exp_ce[n] = MAXT; exp_fail[n] = 1;
                if (MAXT + 2 > ntaps) ntaps = MAXT + 2;
            end
        end
        exp_nl = ntaps * R * L;
    endtask

    always @(negedge clk) begin
        int j;
        bit e;
        if (!rst_n) begin
            for (int n = 0; n < LANES; n++) dly[n] = 0;
            k = 0;
        end else if (!run) begin
            k = 0;
        end else begin
            if (k == 0) begin
                for (int n = 0; n < LANES; n++) dly[n] = 0;
                chk("busy_at_start", int'(busy), 0);
            end else if (k <= exp_nl) begin
                j = k / L - 1;
                chk("busy", int'(busy), 1);
                chk("done_low", int'(done), 0);
                chk("cfail_low", int'(cfail), 0);
                chk("dqs", int'(dqs), int'((k - 1) % L == 0));
                for (int n = 0; n < LANES; n++) begin
                    e = (k % L == 0) && (k < exp_nl) && (j % R == R - 1) && (j / R < exp_ce[n]);
                    chk($sformatf("ce%0d", n), int'(ce[n]), int'(e));
                    chk($sformatf("lfail%0d", n), int'(lfail[n]), int'(exp_fail[n] && k > (MAXT + 1) * R * L));
                    chk($sformatf("tap%0d", n), lane_tap(n), dly[n]);
                    dly[n] += int'(ce[n]);
                end
            end else if (k == exp_nl + 1) begin
                chk("busy_end", int'(busy), 0);
                chk("done_end", int'(done), 1);
                chk("cfail_end", int'(cfail), int'(exp_fail[0] | exp_fail[1]));
                for (int n = 0; n < LANES; n++) begin
                    chk($sformatf("lfail_end%0d", n), int'(lfail[n]), int'(exp_fail[n]));
                    chk($sformatf("tap_end%0d", n), lane_tap(n), exp_tap[n]);
                end
            end
            k++;
        end
    end

    task automatic run_cal(input int tid, input int poke_k);
        int budget;
        test_id = tid;
        build_model(tid);
        @(posedge clk); #1;
        start = 1'b1;
        run   = 1'b1;
        budget = exp_nl + 20;
        do begin
            @(posedge clk); #1;
            start = (k == poke_k);
            budget--;
        end while (k <= exp_nl + 1 && budget > 0);
        start = 1'b0;
        if (budget <= 0) chk("run_timeout", 1, 0);
        run = 1'b0;
        @(posedge clk); #1;
    endtask

    // Runs until cycle index tgt of a calibration with pattern tid; leaves run set.
    task automatic run_until(input int tid, input int tgt);
        int budget;
        test_id = tid;
        build_model(tid);
        @(posedge clk); #1;
        start = 1'b1;
        run   = 1'b1;
        budget = tgt + 20;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            budget--;
        end while (k != tgt && budget > 0);
        if (budget <= 0) chk("wait_timeout", 1, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_dqs", int'(dqs), 0);
        chk("rst_tap", int'(tap), 0);
        chk("rst_lfail", int'(lfail), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Both lanes transition at tap 7.
        run_cal(1, -1);
        chk("t1_lane0", lane_tap(0), 7);
        chk("t1_lane1", lane_tap(1), 7);
        chk("t1_ce0", dly[0], 7);
        chk("t1_ce1", dly[1], 7);
        chk("t1_cfail", int'(cfail), 0);

        // Lanes at 3 and 20; a start pulse while busy must be ignored.
        run_cal(2, 12 * R);
        chk("t2_lane0", lane_tap(0), 3);
        chk("t2_lane1", lane_tap(1), 20);

        // Lane 1 stuck at 0.
        run_cal(3, -1);
        chk("t3_lfail", int'(lfail), 2);
        chk("t3_lane1", lane_tap(1), 31);
        chk("t3_lane0", lane_tap(0), 5);
        chk("t3_cfail", int'(cfail), 1);

        // Early 1-region must not lock.
        run_cal(4, -1);
        chk("t4_lane0", lane_tap(0), 10);
        chk("t4_lane1", lane_tap(1), 10);

`ifdef SDDR_WL_FILTER_EN
        // 1,0,0,1 at tap 6 is not a majority; 1,1,0,1 at tap 7 is.
        run_cal(5, -1);
        chk("t5_lane0", lane_tap(0), 7);
        chk("t5_lane1", lane_tap(1), 7);
`endif

        // Abort in the first SETTLE cycle of tap 4.
        run_until(1, 4 * R * L + 2);
        abort = 1'b1;
        run   = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("ab_busy", int'(busy), 0);
        chk("ab_done", int'(done), 0);
        chk("ab_lane0", lane_tap(0), 4);
        chk("ab_lane1", lane_tap(1), 4);

        // Start and abort together in IDLE: stays idle, taps untouched.
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", int'(busy), 0);
        chk("sa_lane0", lane_tap(0), 4);
        @(posedge clk); #1;

        // Restart runs from tap 0 again.
        run_cal(1, -1);
        chk("rs_lane0", lane_tap(0), 7);

        // Reset during the STEP of tap 2.
        run_until(1, 3 * R * L);
        run = 1'b0;
        chk("pre_rst_ce", int'(ce), 3);
        rst_n = 1'b0;
        #1;
        chk("mr_busy", int'(busy), 0);
        chk("mr_ce", int'(ce), 0);
        chk("mr_dqs", int'(dqs), 0);
        chk("mr_tap", int'(tap), 0);
        chk("mr_done", int'(done), 0);
        chk("mr_lfail", int'(lfail), 0);
        chk("mr_cfail", int'(cfail), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_busy", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
